inst_fetch: RTL and testbench

Instruction fetch stage: keeps the architectural PC, reads 32-bit instruction words through the memory-controller read port, and presents them to the decode stage on `inst`/`pc_val`. Directly upstream of decode. Fetch of PC+4 starts as soon as decode accepts an instruction. A taken jump or branch reported by execute redirects the PC and squashes the instruction already fetched. An optional direct-mapped instruction cache sits in front of the memory port.

---
 rtl/inst_fetch_if.sv | 37 +++
 rtl/inst_fetch.sv | 186 ++++++++++++++++++
 tb/tb_inst_fetch.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/inst_fetch_if.sv
// -----------------------------------------------------------------------------
// inst_fetch_if
//
// Read port between the instruction fetch stage and the memory controller.
// The fetch stage raises mem_req with a stable mem_addr. The controller
// answers with a one-cycle mem_done pulse and mem_data on the same cycle.
//
// Signals:
//   mem_req   fetch -> mem   read request, held until the mem_done edge
//   mem_addr  fetch -> mem   word address, stable while mem_req is high
//   mem_data  mem -> fetch   read data, valid while mem_done is high
//   mem_done  mem -> fetch   one-cycle completion pulse
//
// Modports:
//   master  fetch-stage side
//   slave   memory-controller side
// -----------------------------------------------------------------------------
interface inst_fetch_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic        mem_done;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_data,
    input  mem_done
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_data,
    output mem_done
  );
endinterface

// File: rtl/inst_fetch.sv
// -----------------------------------------------------------------------------
// inst_fetch
//
// Instruction fetch stage. It keeps the architectural PC and reads 32-bit
// instruction words through the memory-controller read port. Each word is
// presented to decode on inst/pc_val until decode accepts it with id_done.
// A jump or branch taken in execute (jump_en) redirects the PC. It also
// squashes whatever is currently fetched or in flight.
//
// Optional feature: define ICACHE_EN to put a direct-mapped, one-word-per-line
// instruction cache in front of the memory port. If ICACHE_EN is not defined,
// the cache has no storage and every fetch goes to memory.
//
// Parameters:
//   PC_RESET          PC loaded on reset
//   ICACHE_LOG_LINES  log2 of the cache line count (ICACHE_EN builds only)
//
// Ports:
//   clk          clock
//   rst          synchronous, active-high reset
//   rdy          global enable; when low, every register holds its value
//   inst         instruction to decode; 0 means no valid instruction
//   pc_val       PC of inst
//   id_done      one-cycle pulse: decode consumed inst
//   jump_en      one-cycle pulse: redirect to jump_target
//   jump_target  word-aligned redirect PC
//   mem          memory read port (mem_req/mem_addr/mem_data/mem_done)
// -----------------------------------------------------------------------------
module inst_fetch #(
  parameter logic [31:0]  PC_RESET         = 32'h0,
  parameter int unsigned  ICACHE_LOG_LINES = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  output logic [31:0]         inst,
  output logic [31:0]         pc_val,
  input  logic                id_done,
  input  logic                jump_en,
  input  logic [31:0]         jump_target,
  inst_fetch_if.master        mem
);

  // ISSUE : start a fetch of pc (or take a cache hit)
  // FETCH : request outstanding, waiting for mem_done
  // HOLD  : inst valid, waiting for decode to accept it
  typedef enum logic [1:0] {
    ST_ISSUE = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2
  } fetch_state_e;

  fetch_state_e state;
  logic [31:0]  pc;
  // Set when a jump lands while a request is in flight. That request must
  // still finish, because the controller cannot cancel it. Its data is
  // discarded.
  logic         flush;

  logic         hit;
  logic [31:0]  hit_data;

`ifdef ICACHE_EN
  // ---------------------------------------------------------------------------
  // Direct-mapped cache with one 32-bit word per line.
  // index = pc[ICACHE_LOG_LINES+1:2]; tag = pc[31:ICACHE_LOG_LINES+2].
  // ---------------------------------------------------------------------------
  localparam int unsigned LINES = 1 << ICACHE_LOG_LINES;
  localparam int unsigned TAG_W = 30 - ICACHE_LOG_LINES;

  logic [LINES-1:0]            line_valid;
  logic [TAG_W-1:0]            line_tag  [LINES];
  logic [31:0]                 line_data [LINES];

  logic [ICACHE_LOG_LINES-1:0] line_idx;
  logic [TAG_W-1:0]            line_tag_pc;
  logic                        fill_en;

  assign line_idx    = pc[ICACHE_LOG_LINES+1:2];
  assign line_tag_pc = pc[31:ICACHE_LOG_LINES+2];
  assign hit         = line_valid[line_idx] && (line_tag[line_idx] == line_tag_pc);
  assign hit_data    = line_data[line_idx];

  // A fetch that completes without a pending flush fills the line. The
  // fill uses the PC the request was made for, so the line is correct
  // even when a jump arrives on the same edge.
  assign fill_en = rdy && (state == ST_FETCH) && mem.mem_done && !flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      line_valid <= '0;
    end else if (fill_en) begin
      line_valid[line_idx] <= 1'b1;
    end
  end

  // NOTE: the tag/data arrays have no reset. Only the valid bits must start
  // cleared. Leaving the arrays unreset lets them map onto plain RAM.
  always_ff @(posedge clk) begin
    if (!rst && fill_en) begin
      line_tag[line_idx]  <= line_tag_pc;
      line_data[line_idx] <= mem.mem_data;
    end
  end
`else
  // No cache: every ISSUE goes to memory. The line-count parameter has no
  // effect in this build, so it is folded into a dead net here.
  logic [31:0] unused_icache_cfg;
  assign unused_icache_cfg = ICACHE_LOG_LINES;
  assign hit      = 1'b0;
  assign hit_data = '0;
`endif

  // ---------------------------------------------------------------------------
  // Fetch FSM. All outputs are registered. In every state a jump overrides
  // the normal next-PC choice, and the jump wins over id_done.
  // ---------------------------------------------------------------------------
  // NOTE: every register here is assigned with <=. All branches then read
  // the pre-edge values of pc/flush/state. This keeps the jump-overrides
  // pattern in FETCH order-independent.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_ISSUE;
      pc           <= PC_RESET;
      flush        <= 1'b0;
      inst         <= '0;
      pc_val       <= '0;
      mem.mem_req  <= 1'b0;
      mem.mem_addr <= '0;
    end else if (rdy) begin
      unique case (state)
        ST_ISSUE: begin
          if (jump_en) begin
            // Redirect before any request leaves. The next ISSUE uses the
            // new PC.
            pc   <= jump_target;
            inst <= '0;
          end else if (hit) begin
            inst   <= hit_data;
            pc_val <= pc;
            state  <= ST_HOLD;
          end else begin
            mem.mem_req  <= 1'b1;
            mem.mem_addr <= pc;
            state        <= ST_FETCH;
          end
        end

        ST_FETCH: begin
          if (mem.mem_done) begin
            mem.mem_req <= 1'b0;
            if (flush || jump_en) begin
              flush <= 1'b0;
              state <= ST_ISSUE;
            end else begin
              inst   <= mem.mem_data;
              pc_val <= pc;
              state  <= ST_HOLD;
            end
          end else if (jump_en) begin
            flush <= 1'b1;
          end
          if (jump_en) begin
            pc   <= jump_target;
            inst <= '0;
          end
        end

        ST_HOLD: begin
          if (jump_en) begin
            pc    <= jump_target;
            inst  <= '0;
            state <= ST_ISSUE;
          end else if (id_done) begin
            inst  <= '0;
            pc    <= pc + 32'd4;
            state <= ST_ISSUE;
          end
        end

        default: state <= ST_ISSUE;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch
//
// Bench for inst_fetch. A behavioural memory answers read requests with a
// fixed function of the address after a programmable latency. The program
// order is modelled as one expected PC: +4 on accept, target on a jump.
// Every instruction delivered to decode must be mem_word(expected PC).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy = 1'b1;
  logic        id_done = 1'b0;
  logic        jump_en = 1'b0;
  logic [31:0] jump_target = '0;
  logic [31:0] inst;
  logic [31:0] pc_val;

  inst_fetch_if mem_bus ();

  inst_fetch dut (
    .clk         (clk),
    .rst         (rst),
    .rdy         (rdy),
    .inst        (inst),
    .pc_val      (pc_val),
    .id_done     (id_done),
    .jump_en     (jump_en),
    .jump_target (jump_target),
    .mem         (mem_bus)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  int          mem_lat = 3;
  int          req_rises = 0;
  bit          rdy_jitter = 1'b0;
  logic [31:0] model_pc = 32'h0;

  // Memory contents: nop at 0, otherwise a nonzero hash of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0000_0013;
    return (a * 32'h9E37_79B1) | 32'h1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Memory controller model. It acts just after each edge and is gated by
  // rdy in the same way as the DUT.
  bit resp_busy = 1'b0;
  int resp_cnt  = 0;
  initial begin
    bit edge_rdy;
    bit edge_rst;
    mem_bus.mem_done = 1'b0;
    mem_bus.mem_data = '0;
    forever begin
      @(posedge clk);
      edge_rdy = rdy;
      edge_rst = rst;
      #2;
      if (edge_rst) begin
        resp_busy        = 1'b0;
        mem_bus.mem_done = 1'b0;
      end else if (edge_rdy) begin
        if (mem_bus.mem_done) begin
          mem_bus.mem_done = 1'b0;
        end else if (!resp_busy) begin
          if (mem_bus.mem_req) begin
            resp_busy = 1'b1;
            resp_cnt  = mem_lat;
          end
        end else begin
          resp_cnt--;
          if (resp_cnt <= 0) begin
            mem_bus.mem_done = 1'b1;
            mem_bus.mem_data = mem_word(mem_bus.mem_addr);
            resp_busy        = 1'b0;
          end
        end
      end
    end
  end

  // Handshake monitor: counts requests. While a request is outstanding,
  // the address must stay put.
  initial begin
    logic        prev_req  = 1'b0;
    logic [31:0] prev_addr = '0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_bus.mem_req && !prev_req) req_rises++;
      if (mem_bus.mem_req && prev_req) check("addr_stable", mem_bus.mem_addr, prev_addr);
      prev_req  = mem_bus.mem_req;
      prev_addr = mem_bus.mem_addr;
    end
  end

  task automatic pulse(input bit do_id, input bit do_jump, input logic [31:0] tgt);
    id_done     = do_id;
    jump_en     = do_jump;
    jump_target = tgt;
    @(negedge clk);
    id_done = 1'b0;
    jump_en = 1'b0;
  endtask

  task automatic wait_inst(input string tag);
    int n = 0;
    while (inst == 32'h0 && n < 200) begin
      if (rdy_jitter) rdy = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      n++;
    end
    rdy = 1'b1;
    n_cmp++;
    assert (inst != 32'h0) else begin
      n_err++;
      $error("FAIL %s_timeout: inst observed %h, required nonzero within 200 cycles", tag, inst);
    end
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (mem_bus.mem_req !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_req"}, {31'h0, mem_bus.mem_req}, 32'h1);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (mem_bus.mem_done !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done"}, {31'h0, mem_bus.mem_done}, 32'h1);
  endtask

  task automatic check_delivered(input string tag);
    check({tag, "_inst"}, inst, mem_word(model_pc));
    check({tag, "_pc_val"}, pc_val, model_pc);
  endtask

  initial begin
    logic [31:0] tgt;
    logic [31:0] hold_addr;
    logic [31:0] hold_inst;
    logic        hold_req;
    int          rises0;
    int          kind;

    // ---------------- reset ----------------
    repeat (3) @(negedge clk);
    check("rst_inst", inst, 32'h0);
    check("rst_pc_val", pc_val, 32'h0);
    check("rst_mem_req", {31'h0, mem_bus.mem_req}, 32'h0);
    check("rst_mem_addr", mem_bus.mem_addr, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    check("first_req", {31'h0, mem_bus.mem_req}, 32'h1);
    check("first_addr", mem_bus.mem_addr, 32'h0);

    // ---------------- first fetch, 3-cycle memory ----------------
    wait_done("first");
    check("inst_before_done_edge", inst, 32'h0);
    @(negedge clk);
    check("first_inst", inst, 32'h0000_0013);
    check("first_pc_val", pc_val, 32'h0);
    check("req_drop", {31'h0, mem_bus.mem_req}, 32'h0);
    repeat (3) @(negedge clk);
    check("hold_inst", inst, 32'h0000_0013);
    pulse(1'b1, 1'b0, '0);
    model_pc = 32'h4;
    check("id_clears_inst", inst, 32'h0);
    wait_req("second");
    check("second_addr", mem_bus.mem_addr, 32'h4);
    wait_inst("second");
    check_delivered("second");

    // ---------------- jump while fetch of 8 outstanding ----------------
    pulse(1'b1, 1'b0, '0);
    wait_req("fetch8");
    check("fetch8_addr", mem_bus.mem_addr, 32'h8);
    pulse(1'b0, 1'b1, 32'h100);
    model_pc = 32'h100;
    check("flush_inst0", inst, 32'h0);
    wait_done("flush");
    @(negedge clk);
    check("flush_discard", inst, 32'h0);
    wait_req("redirect");
    check("redirect_addr", mem_bus.mem_addr, 32'h100);
    wait_inst("redirect");
    check_delivered("redirect");

    // ---------------- jump and id_done together ----------------
    pulse(1'b0, 1'b1, 32'h20);
    model_pc = 32'h20;
    wait_inst("at20");
    check_delivered("at20");
    pulse(1'b1, 1'b1, 32'h40);
    model_pc = 32'h40;
    wait_req("jump_wins");
    check("jump_wins_addr", mem_bus.mem_addr, 32'h40);
    wait_inst("jump_wins");
    check_delivered("jump_wins");

    // ---------------- pc wrap ----------------
    pulse(1'b0, 1'b1, 32'hFFFF_FFFC);
    model_pc = 32'hFFFF_FFFC;
    wait_inst("top");
    check_delivered("top");
    pulse(1'b1, 1'b0, '0);
    model_pc = model_pc + 32'd4;
`ifndef ICACHE_EN
    wait_req("wrap");
    check("wrap_addr", mem_bus.mem_addr, 32'h0);
`endif
    wait_inst("wrap");
    check_delivered("wrap");

    // ---------------- rdy low during FETCH ----------------
    pulse(1'b0, 1'b1, 32'h200);
    model_pc = 32'h200;
    wait_req("stall");
    hold_req  = mem_bus.mem_req;
    hold_addr = mem_bus.mem_addr;
    hold_inst = inst;
    rdy         = 1'b0;
    jump_en     = 1'b1;     // must be ignored while rdy is low
    jump_target = 32'h300;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      jump_en = 1'b0;
      check("stall_req", {31'h0, mem_bus.mem_req}, {31'h0, hold_req});
      check("stall_addr", mem_bus.mem_addr, hold_addr);
      check("stall_inst", inst, hold_inst);
    end
    rdy = 1'b1;
    wait_inst("stall");
    check_delivered("stall");

`ifdef ICACHE_EN
    // ---------------- cache loop 0 -> 4 -> 8 -> 0 ----------------
    pulse(1'b0, 1'b1, 32'h0);
    model_pc = 32'h0;
    for (int i = 0; i < 3; i++) begin
      wait_inst("warm");
      check_delivered("warm");
      if (i < 2) begin
        pulse(1'b1, 1'b0, '0);
        model_pc = model_pc + 32'd4;
      end
    end
    rises0 = req_rises;
    pulse(1'b0, 1'b1, 32'h0);
    model_pc = 32'h0;
    check("hit_gap_jump", inst, 32'h0);
    @(negedge clk);
    check_delivered("hit0");
    for (int i = 0; i < 2; i++) begin
      pulse(1'b1, 1'b0, '0);
      model_pc = model_pc + 32'd4;
      check("hit_gap_id", inst, 32'h0);
      @(negedge clk);
      check_delivered("hit_loop");
    end
    check("hit_no_req", req_rises - rises0, 32'h0);
`endif

    // ---------------- randomized program flow ----------------
    rdy_jitter = 1'b1;
    for (int it = 0; it < 60; it++) begin
      kind    = $urandom_range(0, 3);
      mem_lat = $urandom_range(1, 5);
      if ($urandom_range(0, 1) == 1) tgt = 32'($urandom_range(0, 15)) * 32'd4;
      else tgt = $urandom & 32'hFFFF_FFFC;
      case (kind)
        0: begin
          pulse(1'b1, 1'b0, '0);
          model_pc = model_pc + 32'd4;
        end
        1: begin
          pulse(1'b0, 1'b1, tgt);
          model_pc = tgt;
        end
        2: begin
          pulse(1'b1, 1'b1, tgt);
          model_pc = tgt;
        end
        default: begin
          pulse(1'b1, 1'b0, '0);
          repeat ($urandom_range(0, 4)) @(negedge clk);
          pulse(1'b0, 1'b1, tgt);
          model_pc = tgt;
        end
      endcase
      wait_inst("rnd");
      check_delivered("rnd");
    end
    rdy_jitter = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
